// File: rtl/state_seq_checker.sv
// Lock/consistency checker for a 6-state cyclic sequencer (A..F = 0..5).
// Define SEQ_CHK_STALL_EN to treat a repeated code as a legal hold.
module state_seq_checker #(
    parameter int LOCK_CNT = 6,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       state_in,
    input  logic             state_vld,
    input  logic             cnt_clr,
    output logic             locked,
    output logic [2:0]       expected,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt
);

`ifdef SEQ_CHK_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);
    localparam logic [RUN_W-1:0]  LOCK_V = RUN_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] LOSS_V = MISS_W'(LOSS_CNT);

    localparam logic [1:0] E_WRONG   = 2'b01;
    localparam logic [1:0] E_ILLEGAL = 2'b10;
    localparam logic [1:0] E_REPEAT  = 2'b11;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         last_q, last_d;
    logic [2:0]         expected_q, expected_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic               err_pulse_q, err_pulse_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;

    logic               legal, match, rpt, hold, err_inc, wrap_inc;
    logic [RUN_W-1:0]   run_inc;
    logic [MISS_W-1:0]  miss_inc;

    function automatic logic [2:0] succ(input logic [2:0] s);
        return (s == 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    assign legal    = (state_in <= 3'd5);
    assign match    = (state_in == succ(last_q));
    assign rpt      = (state_in == last_q);
    assign hold     = STALL_EN && rpt;
    assign run_inc  = run_cnt_q + RUN_W'(1);
    assign miss_inc = miss_cnt_q + MISS_W'(1);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        expected_d  = expected_q;
        run_cnt_d   = run_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        err_inc     = 1'b0;
        wrap_inc    = 1'b0;
        if (state_vld) begin
            unique case (state_q)
                UNLOCK: begin
                    if (legal) begin
                        last_d    = state_in;
                        run_cnt_d = '0;
                        state_d   = ACQ;
                    end
                end
                ACQ: begin
                    if (!legal) begin
                        state_d   = UNLOCK;
                        run_cnt_d = '0;
                    end else if (match) begin
                        last_d = state_in;
                        if (run_inc == LOCK_V) begin
                            state_d    = LOCKED;
                            run_cnt_d  = '0;
                            miss_cnt_d = '0;
                            expected_d = succ(state_in);
                        end else begin
                            run_cnt_d = run_inc;
                        end
                    end else if (!hold) begin
                        last_d    = state_in;
                        run_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (legal && match) begin
                        last_d     = state_in;
                        expected_d = succ(state_in);
                        miss_cnt_d = '0;
                        wrap_inc   = (state_in == 3'd0);
                    end else if (!(legal && hold)) begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        if (!legal) begin
                            err_code_d = E_ILLEGAL;
                        end else begin
                            err_code_d = rpt ? E_REPEAT : E_WRONG;
                            last_d     = state_in;
                            expected_d = succ(state_in);
                        end
                        // Final miss drops lock on the same update as its pulse
                        if (miss_inc == LOSS_V) begin
                            state_d    = UNLOCK;
                            miss_cnt_d = '0;
                            expected_d = 3'd0;
                        end else begin
                            miss_cnt_d = miss_inc;
                        end
                    end
                end
                default: begin
                    state_d    = UNLOCK;
                    expected_d = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (wrap_inc) begin
            wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
        end
        if (cnt_clr) begin
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= UNLOCK;
            last_q      <= 3'd0;
            expected_q  <= 3'd0;
            run_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            expected_q  <= expected_d;
            run_cnt_q   <= run_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign expected  = expected_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;
    assign wrap_cnt  = wrap_cnt_q;

endmodule

// File: tb/tb_state_seq_checker.sv
// Scoreboard bench for state_seq_checker: directed scenarios then random
// traffic, checked against a mode/history reference model.
module tb_state_seq_checker;

    localparam int LK = 6;
    localparam int LS = 3;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef SEQ_CHK_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    state_in = 3'd0;
    logic          state_vld = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          locked;
    logic [2:0]    expected;
    logic          err_pulse;
    logic [1:0]    err_code;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] wrap_cnt;

    state_seq_checker #(.LOCK_CNT(LK), .LOSS_CNT(LS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .state_in(state_in),
        .state_vld(state_vld), .cnt_clr(cnt_clr), .locked(locked),
        .expected(expected), .err_pulse(err_pulse), .err_code(err_code),
        .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit lk;
        int ex;
        bit p;
        int code;
        int ec;
        int wc;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nbad = 0;

    // reference model: mode 0 = hunting, 1 = acquiring, 2 = locked
    int m_mode, m_last, m_run, m_miss, m_errs, m_wraps, m_code;
    bit m_pulse;

    task automatic model_step(input bit rn, input bit vld, input int s,
                              input bit clr);
        bit legal, rep, hold, err, wrap;
        int nxt;
        err  = 0;
        wrap = 0;
        if (!rn) begin
            m_mode = 0; m_last = 0; m_run = 0; m_miss = 0;
            m_errs = 0; m_wraps = 0; m_code = 0; m_pulse = 0;
            return;
        end
        m_pulse = 0;
        if (vld) begin
            legal = (s < 6);
            nxt   = (m_last + 1) % 6;
            rep   = (s == m_last);
            hold  = STALL && rep;
            if (m_mode == 0) begin
                if (legal) begin
                    m_last = s; m_run = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (!legal) m_mode = 0;
                else if (s == nxt) begin
                    m_last = s;
                    m_run++;
                    if (m_run == LK) begin
                        m_mode = 2; m_run = 0; m_miss = 0;
                    end
                end else if (!hold) begin
                    m_last = s; m_run = 0;
                end
            end else begin
                if (legal && s == nxt) begin
                    m_last = s; m_miss = 0; wrap = (s == 0);
                end else if (!(legal && hold)) begin
                    err = 1;
                    m_pulse = 1;
                    m_code = !legal ? 2 : (rep ? 3 : 1);
                    if (legal) m_last = s;
                    m_miss++;
                    if (m_miss == LS) begin
                        m_mode = 0; m_miss = 0;
                    end
                end
            end
        end
        if (err && m_errs < CMAX) m_errs++;
        if (wrap) m_wraps = (m_wraps + 1) % (CMAX + 1);
        if (clr) begin
            m_errs = 0; m_wraps = 0;
        end
    endtask

    task automatic step(input bit rn, input bit vld, input int s,
                        input bit clr);
        exp_t e;
        @(posedge clk);
        #2;
        rst_n     = rn;
        state_vld = vld;
        state_in  = s[2:0];
        cnt_clr   = clr;
        model_step(rn, vld, s, clr);
        e.lk   = (m_mode == 2);
        e.ex   = (m_mode == 2) ? (m_last + 1) % 6 : 0;
        e.p    = m_pulse;
        e.code = m_code;
        e.ec   = m_errs;
        e.wc   = m_wraps;
        q.push_back(e);
    endtask

    task automatic smp(input int s);
        step(1'b1, 1'b1, s, 1'b0);
    endtask

    task automatic next_ok();
        smp((m_last + 1) % 6);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            nvec++;
            if (locked !== e.lk || expected !== 3'(e.ex) ||
                err_pulse !== e.p || err_code !== 2'(e.code) ||
                err_cnt !== CW'(e.ec) || wrap_cnt !== CW'(e.wc)) begin
                nbad++;
                $display("FAIL vec%0d t=%0t: got lk=%b ex=%0d p=%b code=%0d ec=%0d wc=%0d, want lk=%b ex=%0d p=%b code=%0d ec=%0d wc=%0d",
                         nvec, $time, locked, expected, err_pulse, err_code,
                         err_cnt, wrap_cnt, e.lk, e.ex, e.p, e.code, e.ec,
                         e.wc);
            end
        end
    end

    initial begin
        int v;
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 3, 1'b0);
        // acquire lock, full cycle, wrong successor
        for (int i = 0; i < 7; i++) smp(i % 6);
        for (int i = 1; i <= 6; i++) smp(i % 6);
        smp(1); smp(2); smp(4);
        step(1'b1, 1'b0, 7, 1'b0);
        smp(5);
        // illegal codes drop lock after three misses
        smp(7); smp(7); smp(7);
        smp(7);
        // relock, then a repeat at last=3
        for (int i = 0; i < 7; i++) smp(i % 6);
        smp(1); smp(2); smp(3); smp(3);
        next_ok();
        // saturate the error counter
        for (int i = 0; i < 20; i++) begin
            smp(6);
            next_ok();
        end
        step(1'b1, 1'b1, 7, 1'b1);
        next_ok();
        step(1'b0, 1'b1, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        // random traffic biased toward the correct successor
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 8) v = (m_last + 1) % 6;
            else v = $urandom_range(0, 7);
            step($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0, v,
                 $urandom_range(0, 39) == 0);
        end
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            nbad++;
            $display("FAIL drain: %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
